uart_frame_decoder: RTL and testbench

//  Command stage between the UART_0 receiver/transmitter and the controller's shared 'data' bus.

---
 rtl/uart_frame_decoder_pkg.sv | 30 +++
 rtl/uart_frame_decoder_byte_timeout.sv | 36 +++
 rtl/uart_frame_decoder.sv | 151 +++++++++++++++
 tb/tb_uart_frame_decoder.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_decoder_pkg.sv
// uart_frame_decoder_pkg
//   Shared definitions for the UART frame decoder: FSM state type,
//   opcode constants, default marker/response bytes and the checksum rule.
package uart_frame_decoder_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_OPC     = 3'd1,
        S_ARG     = 3'd2,
        S_CSUM    = 3'd3,
        S_EXEC_WR = 3'd4,
        S_EXEC_RD = 3'd5,
        S_TX      = 3'd6
    } state_t;

    localparam logic [7:0] OPC_WRITE     = 8'h01;
    localparam logic [7:0] OPC_READ      = 8'h02;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEF_ACK_BYTE  = 8'h5A;
    localparam logic [7:0] DEF_NAK_BYTE  = 8'hEE;

    // A frame is intact when CSUM equals OPC xor ARG.
    function automatic logic csum_ok(input logic [7:0] opc,
                                     input logic [7:0] arg,
                                     input logic [7:0] csum);
        return csum == (opc ^ arg);
    endfunction

endpackage

// File: rtl/uart_frame_decoder_byte_timeout.sv
// byte_timeout
//   Inter-byte idle counter. Counts enabled cycles since the last clear and
//   saturates at TIMEOUT_CYC; expired is high while the count sits there.
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   clr      in  force count to 0 (takes priority over en)
//   en       in  count this cycle
//   expired  out count has reached TIMEOUT_CYC
module byte_timeout #(
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
//   Parses 4-byte RX frames [SYNC, OPC, ARG, CSUM] from UART_0, executes
//   WRITE (drive ARG onto the shared data bus for HOLD_CYC cycles) or READ
//   (sample the bus), and answers every completed frame with one TX byte.
//   SYSCLK     in   system clock
//   SYSRESET   in   asynchronous active-high reset
//   rx_data    in   received byte;  rx_valid in  one-cycle strobe
//   tx_ready   in   TX can accept;  tx_data  out response byte
//   tx_load    out  one-cycle load strobe to TX
//   data_i     in   bus sample;     data_o   out bus drive value
//   data_oe    out  bus output enable
//   busy       out  high whenever not IDLE
//   frame_err  out  pulse on timeout, bad checksum or unknown opcode
//   overrun    out  pulse when a byte arrives during execute/response
module uart_frame_decoder
    import uart_frame_decoder_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter logic [7:0]  ACK_BYTE    = DEF_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE    = DEF_NAK_BYTE,
    parameter int unsigned HOLD_CYC    = 4,
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic              SYSCLK,
    input  logic              SYSRESET,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_load,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_oe,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

    state_t            state;
    logic [7:0]        opc;
    logic [7:0]        arg;
    logic [HOLD_W-1:0] hold_cnt;
    logic              in_frame;
    logic              expired;

    assign in_frame = (state == S_OPC) || (state == S_ARG) || (state == S_CSUM);

    byte_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (SYSCLK),
        .rst    (SYSRESET),
        .clr    (rx_valid || !in_frame),
        .en     (in_frame),
        .expired(expired)
    );

    // tx_data doubles as the response register: it is loaded on entry to TX
    // and simply held afterwards, so the strobe only has to qualify it.
    assign tx_load = (state == S_TX) && tx_ready;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            state     <= S_IDLE;
            opc       <= '0;
            arg       <= '0;
            hold_cnt  <= '0;
            tx_data   <= '0;
            data_o    <= '0;
            data_oe   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state <= S_OPC;
                    end
                end
                S_OPC: begin
                    if (rx_valid) begin
                        opc   <= rx_data;
                        state <= S_ARG;
                    end else if (expired) begin
                        state     <= S_IDLE;
                        frame_err <= 1'b1;
                    end
                end
                S_ARG: begin
                    if (rx_valid) begin
                        arg   <= rx_data;
                        state <= S_CSUM;
                    end else if (expired) begin
                        state     <= S_IDLE;
                        frame_err <= 1'b1;
                    end
                end
                S_CSUM: begin
                    if (rx_valid) begin
                        if (csum_ok(opc, arg, rx_data) && (opc == OPC_WRITE)) begin
                            state    <= S_EXEC_WR;
                            data_o   <= arg;
                            data_oe  <= 1'b1;
                            hold_cnt <= HOLD_W'(HOLD_CYC - 1);
                        end else if (csum_ok(opc, arg, rx_data) && (opc == OPC_READ)) begin
                            state <= S_EXEC_RD;
                        end else begin
                            state     <= S_TX;
                            tx_data   <= NAK_BYTE;
                            frame_err <= 1'b1;
                        end
                    end else if (expired) begin
                        state     <= S_IDLE;
                        frame_err <= 1'b1;
                    end
                end
                S_EXEC_WR: begin
                    overrun <= rx_valid;
                    if (hold_cnt == '0) begin
                        data_oe <= 1'b0;
                        tx_data <= ACK_BYTE;
                        state   <= S_TX;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                S_EXEC_RD: begin
                    overrun <= rx_valid;
                    tx_data <= data_i;
                    state   <= S_TX;
                end
                S_TX: begin
                    overrun <= rx_valid;
                    if (tx_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
module tb_uart_frame_decoder;

    localparam int unsigned HOLD    = 4;
    localparam int unsigned TIMEOUT = 10000;
    localparam logic [7:0]  SYNC    = 8'hA5;
    localparam logic [7:0]  ACK     = 8'h5A;
    localparam logic [7:0]  NAK     = 8'hEE;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] data_i = '0;
    logic [7:0] data_o;
    logic       data_oe;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Event logs filled by the monitor (sampled on the falling edge).
    int         oe_cyc_q[$];
    logic [7:0] oe_val_q[$];
    int         tx_cyc_q[$];
    logic [7:0] tx_val_q[$];
    int         fe_cyc_q[$];
    int         ov_cyc_q[$];

    uart_frame_decoder #(
        .DATA_W     (8),
        .SYNC_BYTE  (SYNC),
        .ACK_BYTE   (ACK),
        .NAK_BYTE   (NAK),
        .HOLD_CYC   (HOLD),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .SYSCLK   (clk),
        .SYSRESET (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .data_i   (data_i),
        .data_o   (data_o),
        .data_oe  (data_oe),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (data_oe === 1'b1) begin
            oe_cyc_q.push_back(cyc);
            oe_val_q.push_back(data_o);
        end
        if (tx_load === 1'b1) begin
            tx_cyc_q.push_back(cyc);
            tx_val_q.push_back(tx_data);
        end
        if (frame_err === 1'b1) fe_cyc_q.push_back(cyc);
        if (overrun === 1'b1) ov_cyc_q.push_back(cyc);
    end

    // Reference rules: response byte for a completed frame.
    function automatic logic [7:0] model_resp(input logic [7:0] o, input logic [7:0] a,
                                              input logic [7:0] c, input logic [7:0] din);
        if (c != (o ^ a)) return NAK;
        if (o == 8'h01) return ACK;
        if (o == 8'h02) return din;
        return NAK;
    endfunction

    // Cycles after the CSUM byte at which tx_load is seen (tx_ready held 1).
    function automatic int model_tx_delay(input logic [7:0] o, input logic [7:0] a,
                                          input logic [7:0] c);
        if (c == (o ^ a) && o == 8'h01) return HOLD + 1;
        if (c == (o ^ a) && o == 8'h02) return 2;
        return 1;
    endfunction

    function automatic bit model_good_write(input logic [7:0] o, input logic [7:0] a,
                                            input logic [7:0] c);
        return (c == (o ^ a)) && (o == 8'h01);
    endfunction

    task automatic clear_logs();
        oe_cyc_q.delete(); oe_val_q.delete();
        tx_cyc_q.delete(); tx_val_q.delete();
        fe_cyc_q.delete(); ov_cyc_q.delete();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Entered and left at #1 after a rising edge; returns the cycle number
    // in which the byte was presented.
    task automatic send_byte(input logic [7:0] b, output int at);
        rx_valid = 1'b1;
        rx_data  = b;
        at       = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] o, input logic [7:0] a, input logic [7:0] c,
                              input int gap_max, output int csum_at);
        int t;
        logic [7:0] bytes [4];
        bytes[0] = SYNC; bytes[1] = o; bytes[2] = a; bytes[3] = c;
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], t);
            if (i != 3 && gap_max > 0) idle_cycles(int'($urandom_range(gap_max, 0)));
        end
        csum_at = t;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s wait_idle: busy=%b still high after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #20;
        tests++;
        if ({tx_data, tx_load, data_o, data_oe, busy, frame_err, overrun} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: tx_data=%h tx_load=%b data_o=%h data_oe=%b busy=%b fe=%b ov=%b, required all 0",
                     tx_data, tx_load, data_o, data_oe, busy, frame_err, overrun);
        end
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_write();
        int n;
        clear_logs();
        tx_ready = 1'b1;
        send_frame(8'h01, 8'h3C, 8'h3D, 0, n);
        wait_idle(50, "write");
        idle_cycles(2);
        tests++;
        if (oe_cyc_q.size() != HOLD || oe_cyc_q[0] != n + 1) begin
            fails++;
            $display("FAIL write_oe_window: %0d cycles starting at +%0d, required %0d cycles at +1",
                     oe_cyc_q.size(), (oe_cyc_q.size() > 0) ? oe_cyc_q[0] - n : -1, HOLD);
        end
        tests++;
        if (oe_val_q.size() == 0 || oe_val_q[0] !== 8'h3C || oe_val_q[oe_val_q.size()-1] !== 8'h3C) begin
            fails++;
            $display("FAIL write_data_o: data_o=%h, required 3c", (oe_val_q.size() > 0) ? oe_val_q[0] : 8'hxx);
        end
        tests++;
        if (tx_val_q.size() != 1 || tx_val_q[0] !== ACK || tx_cyc_q[0] != n + HOLD + 1) begin
            fails++;
            $display("FAIL write_tx: %0d loads, first=%h at +%0d, required one load 5a at +%0d",
                     tx_val_q.size(), (tx_val_q.size() > 0) ? tx_val_q[0] : 8'hxx,
                     (tx_cyc_q.size() > 0) ? tx_cyc_q[0] - n : -1, HOLD + 1);
        end
    endtask

    task automatic test_read();
        int n;
        clear_logs();
        data_i = 8'hC3;
        send_frame(8'h02, 8'h00, 8'h02, 0, n);
        wait_idle(50, "read");
        idle_cycles(2);
        tests++;
        if (oe_cyc_q.size() != 0) begin
            fails++;
            $display("FAIL read_no_oe: data_oe high for %0d cycles, required 0", oe_cyc_q.size());
        end
        tests++;
        if (tx_val_q.size() != 1 || tx_val_q[0] !== 8'hC3 || tx_cyc_q[0] != n + 2) begin
            fails++;
            $display("FAIL read_tx: %0d loads, first=%h at +%0d, required c3 at +2",
                     tx_val_q.size(), (tx_val_q.size() > 0) ? tx_val_q[0] : 8'hxx,
                     (tx_cyc_q.size() > 0) ? tx_cyc_q[0] - n : -1);
        end
        data_i = '0;
    endtask

    task automatic test_bad_csum();
        int n;
        clear_logs();
        send_frame(8'h01, 8'h3C, 8'h00, 0, n);
        wait_idle(50, "bad_csum");
        idle_cycles(2);
        tests++;
        if (fe_cyc_q.size() != 1 || fe_cyc_q[0] != n + 1) begin
            fails++;
            $display("FAIL bad_csum_frame_err: %0d pulses, first at +%0d, required one at +1",
                     fe_cyc_q.size(), (fe_cyc_q.size() > 0) ? fe_cyc_q[0] - n : -1);
        end
        tests++;
        if (tx_val_q.size() != 1 || tx_val_q[0] !== NAK) begin
            fails++;
            $display("FAIL bad_csum_tx: %0d loads, first=%h, required one ee",
                     tx_val_q.size(), (tx_val_q.size() > 0) ? tx_val_q[0] : 8'hxx);
        end
        tests++;
        if (oe_cyc_q.size() != 0) begin
            fails++;
            $display("FAIL bad_csum_no_oe: data_oe high %0d cycles, required 0", oe_cyc_q.size());
        end
    endtask

    task automatic test_timeout();
        int m, n, waited;
        clear_logs();
        send_byte(SYNC, m);
        send_byte(8'h01, m);
        waited = 0;
        while (fe_cyc_q.size() == 0 && waited < TIMEOUT + 50) begin
            @(posedge clk); #1;
            waited++;
        end
        idle_cycles(2);
        tests++;
        if (fe_cyc_q.size() != 1 || fe_cyc_q[0] - m < TIMEOUT || fe_cyc_q[0] - m > TIMEOUT + 2) begin
            fails++;
            $display("FAIL timeout_frame_err: %0d pulses, first at +%0d, required one near +%0d",
                     fe_cyc_q.size(), (fe_cyc_q.size() > 0) ? fe_cyc_q[0] - m : -1, TIMEOUT);
        end
        tests++;
        if (busy !== 1'b0 || tx_cyc_q.size() != 0) begin
            fails++;
            $display("FAIL timeout_idle: busy=%b loads=%0d, required busy 0 and no load", busy, tx_cyc_q.size());
        end
        clear_logs();
        send_frame(8'h01, 8'h77, 8'h76, 0, n);
        wait_idle(50, "timeout_recover");
        idle_cycles(2);
        tests++;
        if (tx_val_q.size() != 1 || tx_val_q[0] !== ACK || oe_cyc_q.size() != HOLD) begin
            fails++;
            $display("FAIL timeout_recover: loads=%0d first=%h oe_cycles=%0d, required one 5a and %0d oe cycles",
                     tx_val_q.size(), (tx_val_q.size() > 0) ? tx_val_q[0] : 8'hxx, oe_cyc_q.size(), HOLD);
        end
    endtask

    task automatic test_tx_stall();
        int n, x;
        clear_logs();
        tx_ready = 1'b0;
        send_frame(8'h01, 8'h11, 8'h10, 0, n);
        send_byte(8'h99, x);
        idle_cycles(50);
        tests++;
        if (busy !== 1'b1 || tx_cyc_q.size() != 0) begin
            fails++;
            $display("FAIL stall_hold: busy=%b loads=%0d, required busy 1 and no load", busy, tx_cyc_q.size());
        end
        tests++;
        if (ov_cyc_q.size() != 1 || ov_cyc_q[0] != x + 1) begin
            fails++;
            $display("FAIL stall_overrun: %0d pulses, first at +%0d, required one at +1",
                     ov_cyc_q.size(), (ov_cyc_q.size() > 0) ? ov_cyc_q[0] - x : -1);
        end
        tx_ready = 1'b1;
        wait_idle(10, "stall_release");
        idle_cycles(2);
        tests++;
        if (tx_val_q.size() != 1 || tx_val_q[0] !== ACK) begin
            fails++;
            $display("FAIL stall_tx: loads=%0d first=%h, required one 5a",
                     tx_val_q.size(), (tx_val_q.size() > 0) ? tx_val_q[0] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid_drive();
        int n;
        clear_logs();
        send_frame(8'h01, 8'h42, 8'h43, 0, n);
        idle_cycles(1);
        tests++;
        if (data_oe !== 1'b1) begin
            fails++;
            $display("FAIL rst_drive_pre: data_oe=%b, required 1", data_oe);
        end
        #10 rst = 1'b1;
        #1;
        tests++;
        if ({tx_data, tx_load, data_o, data_oe, busy, frame_err, overrun} !== '0) begin
            fails++;
            $display("FAIL rst_drive_async: data_oe=%b data_o=%h busy=%b tx_data=%h, required all 0",
                     data_oe, data_o, busy, tx_data);
        end
        idle_cycles(3);
        rst = 1'b0;
        clear_logs();
        idle_cycles(20);
        tests++;
        if (tx_cyc_q.size() != 0 || oe_cyc_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_drive_after: loads=%0d oe_cycles=%0d busy=%b, required none and busy 0",
                     tx_cyc_q.size(), oe_cyc_q.size(), busy);
        end
    endtask

    task automatic test_random_frames();
        int n, junk_at;
        logic [7:0] o, a, c, din, junk;
        tx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(3, 0))
                0, 1:    o = 8'h01;
                2:       o = 8'h02;
                default: o = 8'($urandom);
            endcase
            a   = 8'($urandom);
            c   = ($urandom_range(3, 0) != 0) ? (o ^ a) : 8'($urandom);
            din = 8'($urandom);
            junk = 8'($urandom);
            if (junk == SYNC) junk = 8'h00;
            data_i = din;
            clear_logs();
            send_byte(junk, junk_at);
            send_frame(o, a, c, 3, n);
            wait_idle(50, "random");
            idle_cycles(2);
            tests++;
            if (tx_val_q.size() != 1 || tx_val_q[0] !== model_resp(o, a, c, din)
                || tx_cyc_q[0] != n + model_tx_delay(o, a, c)) begin
                fails++;
                $display("FAIL random_tx[%0d] opc=%h arg=%h cs=%h: loads=%0d first=%h at +%0d, required %h at +%0d",
                         k, o, a, c, tx_val_q.size(), (tx_val_q.size() > 0) ? tx_val_q[0] : 8'hxx,
                         (tx_cyc_q.size() > 0) ? tx_cyc_q[0] - n : -1,
                         model_resp(o, a, c, din), model_tx_delay(o, a, c));
            end
            tests++;
            if (oe_cyc_q.size() != (model_good_write(o, a, c) ? HOLD : 0)
                || (oe_val_q.size() > 0 && oe_val_q[0] !== a)
                || fe_cyc_q.size() != ((model_resp(o, a, c, din) === NAK && !(o == 8'h02 && c == (o ^ a))) ? 1 : 0)) begin
                fails++;
                $display("FAIL random_bus[%0d] opc=%h arg=%h cs=%h: oe_cycles=%0d data_o=%h fe=%0d",
                         k, o, a, c, oe_cyc_q.size(), (oe_val_q.size() > 0) ? oe_val_q[0] : 8'hxx,
                         fe_cyc_q.size());
            end
        end
        data_i = '0;
    endtask

    initial begin
        idle_cycles(1);
        test_reset();
        test_write();
        test_read();
        test_bad_csum();
        test_timeout();
        test_tx_stall();
        test_reset_mid_drive();
        do_reset();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
